// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: register index type,
// sequencing FSM state encoding, and the load-use register match helper.
package hazard_ctrl_pkg;

   typedef logic [4:0] regidx_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DWAIT  = 2'd1,
      HALTED = 2'd2
   } hzstate_t;

   // A load in ID/EX conflicts with IF/ID when it writes a non-zero register
   // that the younger instruction reads.
   function automatic logic reg_match(regidx_t wsel, regidx_t rs, regidx_t rt);
      return (wsel != 5'd0) && ((wsel == rs) || (wsel == rt));
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Port bundle between the pipeline datapath and the hazard controller.
// Handshake: there is no valid/ready pairing here; every status input is
// sampled every cycle as a level, and every latch control output is a level
// that applies to the clock edge ending the current cycle.
// slave  : hazard controller side (consumes pipeline status, drives controls)
// master : pipeline side (drives status, consumes controls)
interface hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   import hazard_ctrl_pkg::*;

   logic             ihit;
   logic             dhit;
   logic             exm_dREN;
   logic             exm_dWEN;
   logic             idex_dREN;
   regidx_t          idex_wsel;
   regidx_t          ifid_rs;
   regidx_t          ifid_rt;
   logic             exm_redirect;
   logic             mwb_halt;

   logic             pc_en;
   logic             ifid_en;
   logic             idex_en;
   logic             exm_en;
   logic             mwb_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic             exm_flush;
   logic             mwb_flush;
   logic             halted;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cycles;
   hzstate_t         state;

   modport slave (
      input  ihit, dhit, exm_dREN, exm_dWEN, idex_dREN, idex_wsel,
             ifid_rs, ifid_rt, exm_redirect, mwb_halt,
      output pc_en, ifid_en, idex_en, exm_en, mwb_en,
             ifid_flush, idex_flush, exm_flush, mwb_flush,
             halted, mem_timeout, stall_cycles, state
   );

   modport master (
      output ihit, dhit, exm_dREN, exm_dWEN, idex_dREN, idex_wsel,
             ifid_rs, ifid_rt, exm_redirect, mwb_halt,
      input  pc_en, ifid_en, idex_en, exm_en, mwb_en,
             ifid_flush, idex_flush, exm_flush, mwb_flush,
             halted, mem_timeout, stall_cycles, state
   );

endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, data-memory wait freeze,
// fetch-miss bubbles, redirect flushes, halt, and a memory-wait watchdog.
// Optional stall performance counter enabled by defining HAZARD_PERF_EN.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int WAIT_LIMIT = 64,
   parameter int CNT_W      = 32
) (
   input  logic          CLK,
   input  logic          nRST,
   hazard_ctrl_if.slave  hz
);

   localparam int              WC_W   = $clog2(WAIT_LIMIT + 1);
   localparam logic [WC_W-1:0] WC_MAX = WC_W'(WAIT_LIMIT);

   hzstate_t        state_q, state_d;
   logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
   logic            timeout_q, timeout_d;

   logic dmem_pend;
   logic loaduse;
   logic pc_en, ifid_en, idex_en, exm_en, mwb_en;
   logic ifid_flush, idex_flush, exm_flush, mwb_flush;

   assign dmem_pend = (hz.exm_dREN | hz.exm_dWEN) & ~hz.dhit;
   assign loaduse   = hz.idex_dREN & reg_match(hz.idex_wsel, hz.ifid_rs, hz.ifid_rt);

   // Latch control decode from current state and live hazard inputs, by priority.
   always_comb begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exm_en     = 1'b1;
      mwb_en     = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      exm_flush  = 1'b0;
      mwb_flush  = 1'b0;
      if (!nRST) begin
         {pc_en, ifid_en, idex_en, exm_en, mwb_en}          = 5'b00000;
         {ifid_flush, idex_flush, exm_flush, mwb_flush}     = 4'b1111;
      end else if (state_q == HALTED) begin
         {pc_en, ifid_en, idex_en, exm_en, mwb_en}          = 5'b00000;
      end else if (dmem_pend) begin
         // Freeze the front of the pipe; WB retires once then sees bubbles.
         {pc_en, ifid_en, idex_en, exm_en} = 4'b0000;
         mwb_flush = 1'b1;
      end else if (hz.exm_redirect) begin
         // Wrong-path instructions in IF/ID and ID/EX are squashed.
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (loaduse) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end else if (!hz.ihit) begin
         pc_en      = 1'b0;
         ifid_flush = 1'b1;
      end
   end

   // Next-state, watchdog count and sticky timeout.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;
      timeout_d  = timeout_q;
      case (state_q)
         RUN: begin
            if (hz.mwb_halt && !dmem_pend) state_d = HALTED;
            else if (dmem_pend)            state_d = DWAIT;
         end
         DWAIT: begin
            if (hz.mwb_halt && !dmem_pend) begin
               state_d = HALTED;
            end else if (dmem_pend) begin
               state_d    = DWAIT;
               wait_cnt_d = (wait_cnt_q == WC_MAX) ? WC_MAX : wait_cnt_q + WC_W'(1);
            end else begin
               state_d = RUN;
            end
         end
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
      if (wait_cnt_d == WC_MAX) timeout_d = 1'b1;
   end

   // FSM, watchdog counter and timeout flag registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_q, stall_d;

   // Count cycles where the PC is held, excluding the halted state; saturating.
   always_comb begin
      stall_d = stall_q;
      if (!pc_en && (state_q != HALTED) && (stall_q != '1))
         stall_d = stall_q + CNT_W'(1);
   end

   // Stall counter register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) stall_q <= '0;
      else       stall_q <= stall_d;
   end

   assign hz.stall_cycles = stall_q;
`else
   assign hz.stall_cycles = '0;
`endif

   assign hz.pc_en       = pc_en;
   assign hz.ifid_en     = ifid_en;
   assign hz.idex_en     = idex_en;
   assign hz.exm_en      = exm_en;
   assign hz.mwb_en      = mwb_en;
   assign hz.ifid_flush  = ifid_flush;
   assign hz.idex_flush  = idex_flush;
   assign hz.exm_flush   = exm_flush;
   assign hz.mwb_flush   = mwb_flush;
   assign hz.halted      = (state_q == HALTED);
   assign hz.mem_timeout = timeout_q;
   assign hz.state       = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (WAIT_LIMIT = 4). Stall counter
// expectations follow HAZARD_PERF_EN.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   localparam int WL = 4;
   localparam int CW = 32;

   // Control vector order: pc, ifid, idex, exm, mwb enables; ifid, idex, exm, mwb flushes
   localparam logic [8:0] V_RST  = 9'b00000_1111;
   localparam logic [8:0] V_RUN  = 9'b11111_0000;
   localparam logic [8:0] V_HALT = 9'b00000_0000;
   localparam logic [8:0] V_FRZ  = 9'b00001_0001;
   localparam logic [8:0] V_RDR  = 9'b11111_1100;
   localparam logic [8:0] V_LU   = 9'b00111_0100;
   localparam logic [8:0] V_MISS = 9'b01111_1000;

   logic CLK = 1'b0;
   logic nRST;
   int   checks = 0;
   int   fails  = 0;

   // Clock and reset
   always #5 CLK = ~CLK;

   hazard_ctrl_if #(.CNT_W(CW)) hz ();

   hazard_ctrl #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .hz   (hz.slave)
   );

   logic [8:0] ctl;
   assign ctl = {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exm_en, hz.mwb_en,
                 hz.ifid_flush, hz.idex_flush, hz.exm_flush, hz.mwb_flush};

   // Driver tasks
   task automatic idle_inputs();
      hz.ihit = 1'b1; hz.dhit = 1'b0; hz.exm_dREN = 1'b0; hz.exm_dWEN = 1'b0;
      hz.idex_dREN = 1'b0; hz.idex_wsel = 5'd0; hz.ifid_rs = 5'd0; hz.ifid_rt = 5'd0;
      hz.exm_redirect = 1'b0; hz.mwb_halt = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge CLK); #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      nRST = 1'b0;
      repeat (2) @(negedge CLK);
      checks++; if (ctl !== V_RST) begin fails++; $display("FAIL reset_ctl: got %b expected %b", ctl, V_RST); end
      checks++; if (hz.halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b expected 0", hz.halted); end
      checks++; if (hz.mem_timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b expected 0", hz.mem_timeout); end
      checks++; if (hz.stall_cycles !== '0) begin fails++; $display("FAIL reset_stall: got %0d expected 0", hz.stall_cycles); end
      nRST = 1'b1;
      @(negedge CLK);
      checks++; if (ctl !== V_RUN) begin fails++; $display("FAIL post_reset_ctl: got %b expected %b", ctl, V_RUN); end
      checks++; if (hz.state !== RUN) begin fails++; $display("FAIL post_reset_state: got %0d expected %0d", hz.state, RUN); end
   endtask

   task automatic test_loaduse();
      next_cycle(); idle_inputs();
      hz.idex_dREN = 1'b1; hz.idex_wsel = 5'd8; hz.ifid_rs = 5'd3; hz.ifid_rt = 5'd8;
      @(negedge CLK);
      checks++; if (ctl !== V_LU) begin fails++; $display("FAIL loaduse_rt: got %b expected %b", ctl, V_LU); end
      // Load has moved on to EX/MEM and completes at once; bubble sits in ID/EX
      next_cycle(); idle_inputs(); hz.exm_dREN = 1'b1; hz.dhit = 1'b1;
      @(negedge CLK);
      checks++; if (ctl !== V_RUN) begin fails++; $display("FAIL loaduse_after: got %b expected %b", ctl, V_RUN); end
      next_cycle(); idle_inputs(); hz.idex_dREN = 1'b1; hz.idex_wsel = 5'd0;
      @(negedge CLK);
      checks++; if (ctl !== V_RUN) begin fails++; $display("FAIL loaduse_r0: got %b expected %b", ctl, V_RUN); end
      next_cycle(); hz.idex_wsel = 5'd5; hz.ifid_rs = 5'd5; hz.ifid_rt = 5'd9;
      @(negedge CLK);
      checks++; if (ctl !== V_LU) begin fails++; $display("FAIL loaduse_rs: got %b expected %b", ctl, V_LU); end
      next_cycle(); hz.ifid_rs = 5'd6; hz.ifid_rt = 5'd7;
      @(negedge CLK);
      checks++; if (ctl !== V_RUN) begin fails++; $display("FAIL loaduse_nomatch: got %b expected %b", ctl, V_RUN); end
   endtask

   task automatic test_dwait();
      next_cycle(); idle_inputs(); hz.exm_dREN = 1'b1;
      @(negedge CLK);
      checks++; if (ctl !== V_FRZ) begin fails++; $display("FAIL dwait_first: got %b expected %b", ctl, V_FRZ); end
      checks++; if (hz.state !== RUN) begin fails++; $display("FAIL dwait_first_state: got %0d expected %0d", hz.state, RUN); end
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         @(negedge CLK);
         checks++; if (ctl !== V_FRZ) begin fails++; $display("FAIL dwait_hold%0d: got %b expected %b", i, ctl, V_FRZ); end
         checks++; if (hz.state !== DWAIT) begin fails++; $display("FAIL dwait_state%0d: got %0d expected %0d", i, hz.state, DWAIT); end
      end
      next_cycle(); hz.dhit = 1'b1;
      @(negedge CLK);
      checks++; if (ctl !== V_RUN) begin fails++; $display("FAIL dwait_dhit: got %b expected %b", ctl, V_RUN); end
      checks++; if (hz.state !== DWAIT) begin fails++; $display("FAIL dwait_dhit_state: got %0d expected %0d", hz.state, DWAIT); end
      next_cycle(); idle_inputs();
      @(negedge CLK);
      checks++; if (hz.state !== RUN) begin fails++; $display("FAIL dwait_return: got %0d expected %0d", hz.state, RUN); end
   endtask

   task automatic test_priority();
      next_cycle(); idle_inputs();
      hz.exm_redirect = 1'b1; hz.ihit = 1'b0;
      hz.idex_dREN = 1'b1; hz.idex_wsel = 5'd8; hz.ifid_rs = 5'd8;
      @(negedge CLK);
      checks++; if (ctl !== V_RDR) begin fails++; $display("FAIL prio_redirect: got %b expected %b", ctl, V_RDR); end
      next_cycle(); hz.exm_dREN = 1'b1; hz.dhit = 1'b0;
      @(negedge CLK);
      checks++; if (ctl !== V_FRZ) begin fails++; $display("FAIL prio_freeze: got %b expected %b", ctl, V_FRZ); end
      // Request withdrawn without dhit: leave DWAIT quietly
      next_cycle(); idle_inputs();
      @(negedge CLK);
      checks++; if (ctl !== V_RUN) begin fails++; $display("FAIL prio_drop_ctl: got %b expected %b", ctl, V_RUN); end
      next_cycle();
      @(negedge CLK);
      checks++; if (hz.state !== RUN) begin fails++; $display("FAIL prio_drop_state: got %0d expected %0d", hz.state, RUN); end
      checks++; if (hz.mem_timeout !== 1'b0) begin fails++; $display("FAIL prio_drop_timeout: got %b expected 0", hz.mem_timeout); end
   endtask

   task automatic test_fetch_miss();
      next_cycle(); idle_inputs(); hz.ihit = 1'b0;
      @(negedge CLK);
      checks++; if (ctl !== V_MISS) begin fails++; $display("FAIL miss_ctl: got %b expected %b", ctl, V_MISS); end
      next_cycle(); hz.idex_dREN = 1'b1; hz.idex_wsel = 5'd12; hz.ifid_rt = 5'd12;
      @(negedge CLK);
      checks++; if (ctl !== V_LU) begin fails++; $display("FAIL miss_vs_loaduse: got %b expected %b", ctl, V_LU); end
   endtask

   task automatic test_watchdog();
      next_cycle(); idle_inputs(); hz.exm_dWEN = 1'b1;
      for (int c = 1; c <= WL + 5; c++) begin
         @(negedge CLK);
         checks++; if (ctl !== V_FRZ) begin fails++; $display("FAIL wd_freeze%0d: got %b expected %b", c, ctl, V_FRZ); end
         if (c == WL + 1) begin
            checks++; if (hz.mem_timeout !== 1'b0) begin fails++; $display("FAIL wd_early: got %b expected 0", hz.mem_timeout); end
         end
         if (c == WL + 2) begin
            checks++; if (hz.mem_timeout !== 1'b1) begin fails++; $display("FAIL wd_rise: got %b expected 1", hz.mem_timeout); end
         end
         if (c < WL + 5) next_cycle();
      end
      next_cycle(); hz.dhit = 1'b1;
      @(negedge CLK);
      checks++; if (ctl !== V_RUN) begin fails++; $display("FAIL wd_dhit: got %b expected %b", ctl, V_RUN); end
      next_cycle(); idle_inputs();
      @(negedge CLK);
      checks++; if (hz.state !== RUN) begin fails++; $display("FAIL wd_state: got %0d expected %0d", hz.state, RUN); end
      checks++; if (hz.mem_timeout !== 1'b1) begin fails++; $display("FAIL wd_sticky: got %b expected 1", hz.mem_timeout); end
   endtask

   task automatic test_reset_mid_dwait();
      next_cycle(); idle_inputs(); hz.exm_dREN = 1'b1;
      next_cycle();
      @(negedge CLK);
      checks++; if (hz.state !== DWAIT) begin fails++; $display("FAIL rmd_pre_state: got %0d expected %0d", hz.state, DWAIT); end
      #2 nRST = 1'b0;
      #1;
      checks++; if (ctl !== V_RST) begin fails++; $display("FAIL rmd_ctl: got %b expected %b", ctl, V_RST); end
      checks++; if (hz.state !== RUN) begin fails++; $display("FAIL rmd_state: got %0d expected %0d", hz.state, RUN); end
      checks++; if (hz.mem_timeout !== 1'b0) begin fails++; $display("FAIL rmd_timeout: got %b expected 0", hz.mem_timeout); end
      checks++; if (hz.halted !== 1'b0) begin fails++; $display("FAIL rmd_halted: got %b expected 0", hz.halted); end
      idle_inputs();
      @(negedge CLK); nRST = 1'b1;
      @(negedge CLK);
      checks++; if (ctl !== V_RUN) begin fails++; $display("FAIL rmd_release: got %b expected %b", ctl, V_RUN); end
   endtask

   task automatic test_halt();
      // Halt is held off while the data access is still pending
      next_cycle(); idle_inputs(); hz.mwb_halt = 1'b1; hz.exm_dREN = 1'b1;
      @(negedge CLK);
      checks++; if (ctl !== V_FRZ) begin fails++; $display("FAIL halt_pend_ctl: got %b expected %b", ctl, V_FRZ); end
      next_cycle(); hz.dhit = 1'b1;
      @(negedge CLK);
      checks++; if (hz.state !== DWAIT) begin fails++; $display("FAIL halt_pend_state: got %0d expected %0d", hz.state, DWAIT); end
      checks++; if (hz.halted !== 1'b0) begin fails++; $display("FAIL halt_not_yet: got %b expected 0", hz.halted); end
      next_cycle(); idle_inputs();
      for (int c = 0; c < 10; c++) begin
         @(negedge CLK);
         checks++; if (ctl !== V_HALT) begin fails++; $display("FAIL halt_ctl%0d: got %b expected %b", c, ctl, V_HALT); end
         checks++; if (hz.halted !== 1'b1) begin fails++; $display("FAIL halt_flag%0d: got %b expected 1", c, hz.halted); end
         next_cycle();
         hz.ihit = c[0];
      end
      @(negedge CLK); nRST = 1'b0;
      #1;
      checks++; if (hz.halted !== 1'b0) begin fails++; $display("FAIL halt_reset: got %b expected 0", hz.halted); end
      idle_inputs();
      @(negedge CLK); nRST = 1'b1;
   endtask

   task automatic test_perf();
      int exp_cnt;
      @(negedge CLK); nRST = 1'b0; idle_inputs();
      @(negedge CLK); nRST = 1'b1;
      for (int k = 0; k < 2; k++) begin
         next_cycle(); idle_inputs(); hz.idex_dREN = 1'b1; hz.idex_wsel = 5'd8; hz.ifid_rt = 5'd8;
         next_cycle(); idle_inputs();
      end
      for (int k = 0; k < 3; k++) begin
         next_cycle(); idle_inputs(); hz.ihit = 1'b0;
      end
      next_cycle(); idle_inputs();
      @(negedge CLK);
`ifdef HAZARD_PERF_EN
      exp_cnt = 5;
`else
      exp_cnt = 0;
`endif
      checks++; if (hz.stall_cycles !== CW'(exp_cnt)) begin fails++; $display("FAIL perf_count: got %0d expected %0d", hz.stall_cycles, exp_cnt); end
   endtask

   // Test sequence and final report
   initial begin
      test_reset();
      test_loaduse();
      test_dwait();
      test_priority();
      test_fetch_miss();
      test_watchdog();
      test_reset_mid_dwait();
      test_halt();
      test_perf();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
